// File: rtl/modulation_segment_sequencer.sv
// modulation_segment_sequencer
// Time-multiplexes one shared if/else segment datapath across NUM_SEG
// segments of a frame. Each segment is issued to the shared datapath, waited
// on for LAT cycles, captured (cond_in selects if_result or else_result) and
// emitted on a valid/ready stream. A done pulse closes the frame.
//
// Optional build feature:
//   `define MODSEQ_IF_COUNT_EN  -> builds the if_count counter (number of
//                                  segments whose condition was true).
//   undefined (default)         -> if_count is tied to zero.
module modulation_segment_sequencer #(
   parameter int NUM_SEG = 8,
   parameter int DATA_W  = 32,
   parameter int LAT     = 2,
   localparam int IDX_W  = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] input_bit,
   output logic [DATA_W-1:0] cond_word,
   output logic [IDX_W-1:0]  seg_idx,
   output logic              issue_valid,
   input  logic [DATA_W-1:0] if_result,
   input  logic [DATA_W-1:0] else_result,
   input  logic              cond_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done,
   output logic [IDX_W:0]    if_count
);

   // Wait counter only needs to reach LAT-1; keep at least one bit so the
   // LAT=0 and LAT=1 builds stay well-formed.
   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int IFC_W = IDX_W + 1;

   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((LAT > 0) ? (LAT - 1) : 0);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SEG - 1);
   localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_EMIT    = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // With zero datapath latency the results are already valid in the cycle
   // after issue, so WAIT is skipped entirely.
   localparam state_t POST_ISSUE = (LAT > 0) ? S_WAIT : S_CAPTURE;

   // 2:1 combine of the shared if/else paths.
   function automatic logic [DATA_W-1:0] combine_sel(
      input logic              sel,
      input logic [DATA_W-1:0] if_val,
      input logic [DATA_W-1:0] else_val
   );
      logic [DATA_W-1:0] res;
      if (sel) begin
         res = if_val;
      end else begin
         res = else_val;
      end
      return res;
   endfunction

   state_t            state_q,       state_d;
   logic [DATA_W-1:0] cond_word_q,   cond_word_d;
   logic [IDX_W-1:0]  seg_idx_q,     seg_idx_d;
   logic [CNT_W-1:0]  wait_cnt_q,    wait_cnt_d;
   logic              issue_valid_q, issue_valid_d;
   logic              out_valid_q,   out_valid_d;
   logic [IDX_W-1:0]  out_idx_q,     out_idx_d;
   logic [DATA_W-1:0] out_data_q,    out_data_d;
   logic              busy_q,        busy_d;
   logic              done_q,        done_d;

   // Next-state logic: frame sequencing, segment stepping and result capture.
   always_comb begin
      state_d     = state_q;
      cond_word_d = cond_word_q;
      seg_idx_d   = seg_idx_q;
      wait_cnt_d  = wait_cnt_q;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_ISSUE;
               cond_word_d = input_bit;
               seg_idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ISSUE: begin
            state_d    = POST_ISSUE;
            wait_cnt_d = '0;
         end

         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               state_d    = S_CAPTURE;
               wait_cnt_d = '0;
            end else begin
               state_d    = S_WAIT;
               wait_cnt_d = wait_cnt_q + CNT_ONE;
            end
         end

         S_CAPTURE: begin
            // The only cycle in which the shared datapath outputs are sampled.
            out_data_d = combine_sel(cond_in, if_result, else_result);
            out_idx_d  = seg_idx_q;
            state_d    = S_EMIT;
         end

         S_EMIT: begin
            if (out_ready) begin
               if (seg_idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  seg_idx_d = seg_idx_q + IDX_ONE;
                  state_d   = S_ISSUE;
               end
            end else begin
               state_d = S_EMIT;
            end
         end

         S_DONE: begin
            // A start seen here is deliberately dropped, not queued.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every status output is a flop.
   always_comb begin
      issue_valid_d = 1'b0;
      out_valid_d   = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b0;

      case (state_d)
         S_ISSUE: begin
            issue_valid_d = 1'b1;
            busy_d        = 1'b1;
         end
         S_WAIT: begin
            busy_d = 1'b1;
         end
         S_CAPTURE: begin
            busy_d = 1'b1;
         end
         S_EMIT: begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         S_IDLE: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Sequencer state and registered outputs; reset aborts any frame silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cond_word_q   <= '0;
         seg_idx_q     <= '0;
         wait_cnt_q    <= '0;
         issue_valid_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_idx_q     <= '0;
         out_data_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cond_word_q   <= cond_word_d;
         seg_idx_q     <= seg_idx_d;
         wait_cnt_q    <= wait_cnt_d;
         issue_valid_q <= issue_valid_d;
         out_valid_q   <= out_valid_d;
         out_idx_q     <= out_idx_d;
         out_data_q    <= out_data_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

`ifdef MODSEQ_IF_COUNT_EN
   localparam logic [IFC_W-1:0] IFC_ONE = IFC_W'(1);

   logic [IFC_W-1:0] if_count_q, if_count_d;

   // Count true conditions per frame; cleared on accepted start, held after done.
   always_comb begin
      if ((state_q == S_IDLE) && start) begin
         if_count_d = '0;
      end else if ((state_q == S_CAPTURE) && cond_in) begin
         if_count_d = if_count_q + IFC_ONE;
      end else begin
         if_count_d = if_count_q;
      end
   end

   // If-count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_count_q <= '0;
      end else begin
         if_count_q <= if_count_d;
      end
   end

   assign if_count = if_count_q;
`else
   assign if_count = {IFC_W{1'b0}};
`endif

   assign cond_word   = cond_word_q;
   assign seg_idx     = seg_idx_q;
   assign issue_valid = issue_valid_q;
   assign out_valid   = out_valid_q;
   assign out_idx     = out_idx_q;
   assign out_data    = out_data_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_modulation_segment_sequencer.sv
// Directed self-checking bench for modulation_segment_sequencer.
// A small behavioural model of the shared datapath answers each issue after
// LAT cycles and drives obvious garbage before that.
`timescale 1ns/1ps
module tb_modulation_segment_sequencer;
   localparam int NUM_SEG = 8;
   localparam int DATA_W  = 32;
   localparam int LAT     = 2;
   localparam int IDX_W   = 3;
`ifdef MODSEQ_IF_COUNT_EN
   localparam bit IFC_EN = 1'b1;
`else
   localparam bit IFC_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DATA_W-1:0] input_bit;
   logic [DATA_W-1:0] cond_word;
   logic [IDX_W-1:0]  seg_idx;
   logic              issue_valid;
   logic [DATA_W-1:0] if_result;
   logic [DATA_W-1:0] else_result;
   logic              cond_in;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_idx;
   logic [DATA_W-1:0] out_data;
   logic              busy;
   logic              done;
   logic [IDX_W:0]    if_count;

   always #5 clk = ~clk;

   modulation_segment_sequencer #(.NUM_SEG(NUM_SEG), .DATA_W(DATA_W), .LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .input_bit(input_bit),
      .cond_word(cond_word), .seg_idx(seg_idx), .issue_valid(issue_valid),
      .if_result(if_result), .else_result(else_result), .cond_in(cond_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
      .out_data(out_data), .busy(busy), .done(done), .if_count(if_count)
   );

   // ---------------- shared datapath model ----------------
   logic [NUM_SEG-1:0] cond_pat = '0;
   int                 dp_age = 0;
   logic [IDX_W-1:0]   dp_idx = '0;
   logic               dp_ok;

   always @(posedge clk) begin
      if (reset) begin
         dp_age <= 0;
         dp_idx <= '0;
      end else if (issue_valid) begin
         dp_age <= 1;
         dp_idx <= seg_idx;
      end else if (dp_age > 0 && dp_age < 1000) begin
         dp_age <= dp_age + 1;
      end
   end

   assign dp_ok       = (dp_age > 0) && (dp_age >= LAT);
   assign if_result   = dp_ok ? (32'hAAAA_0000 + {29'd0, dp_idx}) : 32'hDEAD_0000;
   assign else_result = dp_ok ? (32'h5555_0000 + {29'd0, dp_idx}) : 32'hBEEF_0000;
   assign cond_in     = dp_ok ? cond_pat[dp_idx] : 1'b0;

   function automatic logic [DATA_W-1:0] exp_data(input int k);
      logic [DATA_W-1:0] kk;
      kk = DATA_W'(k);
      return cond_pat[k] ? (32'hAAAA_0000 + kk) : (32'h5555_0000 + kk);
   endfunction

   function automatic int exp_ones();
      int n;
      n = 0;
      for (int i = 0; i < NUM_SEG; i++) n += int'(cond_pat[i]);
      return n;
   endfunction

   // ---------------- bookkeeping ----------------
   int n_pass = 0;
   int n_total = 0;

   int                beat_c [16];
   logic [IDX_W-1:0]  beat_i [16];
   logic [DATA_W-1:0] beat_d [16];
   int                nbeats, done_c, done_n, issue_n, stall_seen;
   bit                issue_in_stall, data_moved, valid_dropped, post_bad, busy0;
   logic [DATA_W-1:0] cw0, cw_end;
   logic [IDX_W:0]    ic0, ic_end;

   // Runs one frame from start; observations indexed by cycle c = edges after T0.
   task automatic run_frame(input logic [DATA_W-1:0] word, input int stall_seg,
                            input int stall_len, input int s1, input int s2);
      int stall_left;
      int post;
      bit prev_stall;
      logic [DATA_W-1:0] hold_d;
      logic [IDX_W-1:0]  hold_i;
      nbeats = 0; done_c = -1; done_n = 0; issue_n = 0; stall_seen = 0;
      issue_in_stall = 1'b0; data_moved = 1'b0; valid_dropped = 1'b0; post_bad = 1'b0;
      stall_left = stall_len; post = -1; prev_stall = 1'b0;
      hold_d = '0; hold_i = '0;
      @(negedge clk);
      input_bit = word; start = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         input_bit = ~word;
         if (c == 0) begin
            busy0 = busy; cw0 = cond_word; ic0 = if_count;
         end
         if (issue_valid) begin
            if (post >= 0) post_bad = 1'b1;
            else issue_n++;
            if (prev_stall) issue_in_stall = 1'b1;
         end
         out_ready = 1'b1;
         if (out_valid && int'(out_idx) == stall_seg && stall_left > 0) begin
            if (stall_left == stall_len) begin
               hold_d = out_data; hold_i = out_idx;
            end else if (out_data !== hold_d || out_idx !== hold_i) begin
               data_moved = 1'b1;
            end
            out_ready = 1'b0;
            stall_left--;
            stall_seen++;
         end else if (prev_stall && !out_valid) begin
            valid_dropped = 1'b1;
         end
         prev_stall = !out_ready;
         if (out_valid && out_ready && nbeats < 16) begin
            beat_c[nbeats] = c; beat_i[nbeats] = out_idx; beat_d[nbeats] = out_data;
            nbeats++;
         end
         if (done) begin
            done_n++;
            if (busy) post_bad = 1'b1;
            if (done_c < 0) begin
               done_c = c; post = 0;
            end
         end
         if (c == s1 || c == s2) start = 1'b1;
         if (post >= 0) begin
            if (post > 0 && (busy || out_valid)) post_bad = 1'b1;
            post++;
            if (post > 8) begin
               cw_end = cond_word; ic_end = if_count;
               break;
            end
         end
      end
   endtask

   // Beat timing, index and data against the expected frame shape.
   task automatic check_beats(input string tag, input int stall_seg, input int stall_len);
      int ec;
      if (nbeats !== NUM_SEG) begin
         $display("FAIL %s beat_count: got %0d expected %0d", tag, nbeats, NUM_SEG);
      end else n_pass++;
      n_total++;
      for (int k = 0; k < NUM_SEG && k < nbeats; k++) begin
         ec = 4 + (LAT + 3) * k + ((stall_seg >= 0 && k >= stall_seg) ? stall_len : 0);
         n_total++;
         if (beat_c[k] !== ec) $display("FAIL %s beat%0d_cycle: got %0d expected %0d", tag, k, beat_c[k], ec);
         else n_pass++;
         n_total++;
         if (beat_i[k] !== IDX_W'(k)) $display("FAIL %s beat%0d_idx: got %0d expected %0d", tag, k, beat_i[k], k);
         else n_pass++;
         n_total++;
         if (beat_d[k] !== exp_data(k)) $display("FAIL %s beat%0d_data: got %h expected %h", tag, k, beat_d[k], exp_data(k));
         else n_pass++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++; if (cond_word !== 32'h0) $display("FAIL rst_cond_word: got %h expected 0", cond_word); else n_pass++;
      n_total++; if (seg_idx !== 3'd0) $display("FAIL rst_seg_idx: got %0d expected 0", seg_idx); else n_pass++;
      n_total++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %b expected 0", issue_valid); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (out_idx !== 3'd0) $display("FAIL rst_out_idx: got %0d expected 0", out_idx); else n_pass++;
      n_total++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h expected 0", out_data); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else n_pass++;
      n_total++; if (if_count !== 4'd0) $display("FAIL rst_if_count: got %0d expected 0", if_count); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_nominal();
      cond_pat = 8'b0101_0101;
      run_frame(32'h1234_5678, -1, 0, -1, -1);
      check_beats("nominal", -1, 0);
      n_total++; if (done_c !== 40) $display("FAIL nominal_done_cycle: got %0d expected 40", done_c); else n_pass++;
      n_total++; if (done_n !== 1) $display("FAIL nominal_done_pulses: got %0d expected 1", done_n); else n_pass++;
      n_total++; if (issue_n !== NUM_SEG) $display("FAIL nominal_issues: got %0d expected %0d", issue_n, NUM_SEG); else n_pass++;
      n_total++; if (busy0 !== 1'b1) $display("FAIL nominal_busy_at_issue: got %b expected 1", busy0); else n_pass++;
      n_total++; if (post_bad !== 1'b0) $display("FAIL nominal_idle_after_done: got %b expected 0", post_bad); else n_pass++;
      n_total++; if (cw0 !== 32'h1234_5678) $display("FAIL nominal_cond_word: got %h expected 12345678", cw0); else n_pass++;
      n_total++; if (cw_end !== 32'h1234_5678) $display("FAIL nominal_cond_word_hold: got %h expected 12345678", cw_end); else n_pass++;
      n_total++;
      if (ic_end !== (IFC_EN ? 4'(exp_ones()) : 4'd0)) $display("FAIL nominal_if_count: got %0d expected %0d", ic_end, IFC_EN ? exp_ones() : 0);
      else n_pass++;
   endtask

   task automatic test_select();
      cond_pat = 8'b1010_1010;
      run_frame(32'h0F0F_F0F0, -1, 0, -1, -1);
      check_beats("select", -1, 0);
   endtask

   task automatic test_backpressure();
      cond_pat = 8'b0101_0101;
      run_frame(32'hA5A5_5A5A, 2, 10, -1, -1);
      check_beats("bp", 2, 10);
      n_total++; if (done_c !== 50) $display("FAIL bp_done_cycle: got %0d expected 50", done_c); else n_pass++;
      n_total++; if (stall_seen !== 10) $display("FAIL bp_stall_cycles: got %0d expected 10", stall_seen); else n_pass++;
      n_total++; if (data_moved !== 1'b0) $display("FAIL bp_data_stable: got %b expected 0", data_moved); else n_pass++;
      n_total++; if (valid_dropped !== 1'b0) $display("FAIL bp_valid_held: got %b expected 0", valid_dropped); else n_pass++;
      n_total++; if (issue_in_stall !== 1'b0) $display("FAIL bp_no_issue: got %b expected 0", issue_in_stall); else n_pass++;
      n_total++; if (issue_n !== NUM_SEG) $display("FAIL bp_issues: got %0d expected %0d", issue_n, NUM_SEG); else n_pass++;
   endtask

   task automatic test_start_ignored();
      cond_pat = 8'b0011_1100;
      // Pulse during segment 5 WAIT and on the done cycle.
      run_frame(32'h0000_0055, -1, 0, 27, 40);
      check_beats("ignore", -1, 0);
      n_total++; if (done_c !== 40) $display("FAIL ignore_done_cycle: got %0d expected 40", done_c); else n_pass++;
      n_total++; if (done_n !== 1) $display("FAIL ignore_done_pulses: got %0d expected 1", done_n); else n_pass++;
      n_total++; if (post_bad !== 1'b0) $display("FAIL ignore_no_new_frame: got %b expected 0", post_bad); else n_pass++;
   endtask

   task automatic test_if_count();
      cond_pat = 8'b1011_0101;
      run_frame(32'h0BAD_F00D, -1, 0, -1, -1);
      n_total++; if (ic_end !== (IFC_EN ? 4'd5 : 4'd0)) $display("FAIL if_count_after_done: got %0d expected %0d", ic_end, IFC_EN ? 5 : 0); else n_pass++;
      repeat (5) @(negedge clk);
      n_total++; if (if_count !== (IFC_EN ? 4'd5 : 4'd0)) $display("FAIL if_count_hold: got %0d expected %0d", if_count, IFC_EN ? 5 : 0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      cond_pat = 8'b1111_0000;
      run_frame(32'h7777_1111, -1, 0, -1, -1);
      n_total++; if (ic0 !== 4'd0) $display("FAIL b2b_if_count_clear: got %0d expected 0", ic0); else n_pass++;
      n_total++; if (cw0 !== 32'h7777_1111) $display("FAIL b2b_cond_word: got %h expected 77771111", cw0); else n_pass++;
      check_beats("b2b", -1, 0);
      n_total++; if (done_c !== 40) $display("FAIL b2b_done_cycle: got %0d expected 40", done_c); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      bit saw_done, saw_busy;
      cond_pat = 8'b1111_1111;
      saw_done = 1'b0; saw_busy = 1'b0;
      @(negedge clk);
      input_bit = 32'hCAFE_0003; start = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      // c = 16: first WAIT cycle of segment 3.
      n_total++; if (seg_idx !== 3'd3) $display("FAIL midrst_pre_seg_idx: got %0d expected 3", seg_idx); else n_pass++;
      n_total++; if (busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b expected 1", busy); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
      n_total++; if (seg_idx !== 3'd0) $display("FAIL midrst_seg_idx: got %0d expected 0", seg_idx); else n_pass++;
      n_total++; if (if_count !== 4'd0) $display("FAIL midrst_if_count: got %0d expected 0", if_count); else n_pass++;
      for (int c = 0; c < 40; c++) begin
         if (done) saw_done = 1'b1;
         if (busy || issue_valid) saw_busy = 1'b1;
         @(negedge clk);
      end
      n_total++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done: got %b expected 0", saw_done); else n_pass++;
      n_total++; if (saw_busy !== 1'b0) $display("FAIL midrst_stays_idle: got %b expected 0", saw_busy); else n_pass++;
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b1;
      input_bit = '0;
      test_reset();
      test_nominal();
      test_select();
      test_backpressure();
      test_start_ignored();
      test_if_count();
      test_back_to_back();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
